ws2812_rx: RTL and testbench



---
 rtl/ws2812_rx.sv | 206 ++++++++++++++++++++
 tb/tb_ws2812_rx.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812 receive decoder: oversamples Din, classifies high pulses by width, assembles 24-bit GRB words.
// Latency: Rx_Valid 3 CLK_IN cycles after the first edge that samples Din low; Frame_Done 3 cycles after the reset gap completes.
// Backpressure: none; Rx_Valid/Frame_Done are single-cycle pulses and the consumer must keep up.
//
// Ports:
//   CLK_IN, RST_N (async active-low)   clock / reset
//   Ws2812_Din                         asynchronous serial line
//   Rx_Data[23:0], Rx_Valid            last completed word (bit 23 first received) + update pulse
//   Rx_Index[7:0]                      word index within frame, saturating at 255
//   Frame_Done                         pulse when the low reset gap completes
//   Rx_Error                           sticky: high pulse longer than HIGH_MAX_CYC
//   Ws2812_Dout                        forwarded data when WS2812_PASSTHRU_EN is defined, else 0
//
// Optional build macro: WS2812_PASSTHRU_EN (daisy-chain emulation: capture word 0, forward the rest).
module ws2812_rx #(
  parameter int F_CLK         = 12_000_000,
  parameter int T_THRESH_NS   = 600,
  parameter int T_RESET_NS    = 50_000,
  parameter int T_HIGH_MAX_NS = 5_000
) (
  input  logic        CLK_IN,
  input  logic        RST_N,
  input  logic        Ws2812_Din,
  output logic [23:0] Rx_Data,
  output logic        Rx_Valid,
  output logic [7:0]  Rx_Index,
  output logic        Frame_Done,
  output logic        Rx_Error,
  output logic        Ws2812_Dout
);

  localparam longint NS_PER_S     = longint'(1_000_000_000);
  localparam int     THRESH_CYC   = int'(longint'(F_CLK) * longint'(T_THRESH_NS) / NS_PER_S);
  localparam int     RESET_CYC    = int'(longint'(F_CLK) * longint'(T_RESET_NS) / NS_PER_S);
  localparam int     HIGH_MAX_CYC = int'(longint'(F_CLK) * longint'(T_HIGH_MAX_NS) / NS_PER_S);
  localparam int     CNT_W        = $clog2(RESET_CYC + 1);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] RESET_SAT  = CNT_W'(RESET_CYC);
  localparam logic [CNT_W-1:0] THRESH     = CNT_W'(THRESH_CYC);
  localparam logic [CNT_W-1:0] HIGH_MAX   = CNT_W'(HIGH_MAX_CYC);

  typedef enum logic [1:0] {
    WAIT_RESET = 2'd0,
    LOW        = 2'd1,
    HIGH       = 2'd2
  } state_t;

  logic [1:0]       sync_ff;
  logic             din_q;
  logic             din_prev;
  logic [CNT_W-1:0] lvl_cnt;
  state_t           state;
  logic [4:0]       bit_cnt;
  logic [22:0]      shift_q;

  logic             rise;
  logic             fall;
  logic             low_done;
  logic             too_long;
  logic             bit_val;
  logic [23:0]      word_nxt;

  // din_q is the synchronized line re-registered once so the FSM decision
  // lands exactly three cycles after the line is first sampled.
  assign rise     = din_q & ~din_prev;
  assign fall     = ~din_q & din_prev;
  // lvl_cnt holds the samples of the current level seen before this cycle,
  // so RESET_LAST plus the current low sample makes RESET_CYC lows.
  assign low_done = ~din_q & ~din_prev & (lvl_cnt == RESET_LAST);
  assign too_long = din_q & (lvl_cnt == HIGH_MAX);
  // On a falling edge lvl_cnt equals the number of high samples.
  assign bit_val  = (lvl_cnt > THRESH);
  assign word_nxt = {shift_q, bit_val};

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync_ff  <= 2'b00;
      din_q    <= 1'b0;
      din_prev <= 1'b0;
      lvl_cnt  <= '0;
    end else begin
      sync_ff  <= {sync_ff[0], Ws2812_Din};
      din_q    <= sync_ff[1];
      din_prev <= din_q;
      // The edge sample is the first sample of the new level.
      if (rise || fall) begin
        lvl_cnt <= CNT_ONE;
      end else if (state == WAIT_RESET && din_q) begin
        lvl_cnt <= '0;
      end else if (lvl_cnt != RESET_SAT) begin
        lvl_cnt <= lvl_cnt + CNT_ONE;
      end
    end
  end

`ifdef WS2812_PASSTHRU_EN
  logic fwd_en;
  logic dout_q;

  // Two cycles behind the synchronized line: din_q is one, dout_q the second.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      dout_q <= 1'b0;
    end else begin
      dout_q <= fwd_en & din_q;
    end
  end

  assign Ws2812_Dout = dout_q;
`else
  logic [7:0] word_idx;

  assign Ws2812_Dout = 1'b0;
`endif

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state      <= WAIT_RESET;
      bit_cnt    <= 5'd0;
      shift_q    <= 23'd0;
      Rx_Data    <= 24'd0;
      Rx_Valid   <= 1'b0;
      Rx_Index   <= 8'd0;
      Frame_Done <= 1'b0;
      Rx_Error   <= 1'b0;
`ifdef WS2812_PASSTHRU_EN
      fwd_en     <= 1'b0;
`else
      word_idx   <= 8'd0;
`endif
    end else begin
      Rx_Valid   <= 1'b0;
      Frame_Done <= 1'b0;
      case (state)
        WAIT_RESET: begin
          bit_cnt  <= 5'd0;
          Rx_Index <= 8'd0;
`ifdef WS2812_PASSTHRU_EN
          fwd_en   <= 1'b0;
`else
          word_idx <= 8'd0;
`endif
          if (low_done) begin
            state    <= LOW;
            Rx_Error <= 1'b0;
          end
        end

        LOW: begin
          if (rise) begin
            state <= HIGH;
          end else if (low_done) begin
            // Partial bits are dropped simply by restarting bit_cnt; the
            // shift register is fully rewritten before the next word.
            Frame_Done <= 1'b1;
            bit_cnt    <= 5'd0;
            Rx_Index   <= 8'd0;
`ifdef WS2812_PASSTHRU_EN
            fwd_en     <= 1'b0;
`else
            word_idx   <= 8'd0;
`endif
          end
        end

        HIGH: begin
          if (too_long) begin
            Rx_Error <= 1'b1;
            bit_cnt  <= 5'd0;
            state    <= WAIT_RESET;
          end else if (fall) begin
            shift_q <= word_nxt[22:0];
            state   <= LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= 5'd0;
`ifdef WS2812_PASSTHRU_EN
              // Only the first word is ours; everything after is forwarded.
              if (!fwd_en) begin
                Rx_Data  <= word_nxt;
                Rx_Valid <= 1'b1;
                fwd_en   <= 1'b1;
              end
`else
              Rx_Data  <= word_nxt;
              Rx_Valid <= 1'b1;
              Rx_Index <= word_idx;
              if (word_idx != 8'hFF) begin
                word_idx <= word_idx + 8'd1;
              end
`endif
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end

        default: begin
          state <= WAIT_RESET;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx (default build): decode, framing, thresholds, errors, reset, index saturation.
// Latency: stimulus is cycle-exact, driven on the falling clock edge.
// Backpressure: none; a monitor captures every Rx_Valid and Frame_Done pulse.
module tb_ws2812_rx;

  logic        CLK_IN = 1'b0;
  logic        RST_N;
  logic        Ws2812_Din;
  logic [23:0] Rx_Data;
  logic        Rx_Valid;
  logic [7:0]  Rx_Index;
  logic        Frame_Done;
  logic        Rx_Error;
  logic        Ws2812_Dout;

  int n_chk  = 0;
  int n_err  = 0;
  int fd_cnt = 0;
  int fd_base;

  logic [23:0] q_dat[$];
  logic [7:0]  q_idx[$];

  always #5 CLK_IN = ~CLK_IN;

  ws2812_rx dut (
    .CLK_IN      (CLK_IN),
    .RST_N       (RST_N),
    .Ws2812_Din  (Ws2812_Din),
    .Rx_Data     (Rx_Data),
    .Rx_Valid    (Rx_Valid),
    .Rx_Index    (Rx_Index),
    .Frame_Done  (Frame_Done),
    .Rx_Error    (Rx_Error),
    .Ws2812_Dout (Ws2812_Dout)
  );

  always @(negedge CLK_IN) begin
    if (Rx_Valid) begin
      q_dat.push_back(Rx_Data);
      q_idx.push_back(Rx_Index);
    end
    if (Frame_Done) fd_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_rx(input string tag, input logic [23:0] dat, input logic [7:0] idx);
    check({tag, "_present"}, 32'(q_dat.size() != 0), 32'd1);
    if (q_dat.size() != 0) begin
      check({tag, "_dat"}, 32'(q_dat.pop_front()), 32'(dat));
      check({tag, "_idx"}, 32'(q_idx.pop_front()), 32'(idx));
    end
  endtask

  task automatic check_none(input string tag);
    check(tag, q_dat.size(), 0);
    q_dat.delete();
    q_idx.delete();
  endtask

  task automatic pulse(input int hi, input int lo);
    Ws2812_Din = 1'b1;
    repeat (hi) @(negedge CLK_IN);
    Ws2812_Din = 1'b0;
    repeat (lo) @(negedge CLK_IN);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(10, 5);
    else   pulse(4, 11);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic idle(input int n);
    Ws2812_Din = 1'b0;
    repeat (n) @(negedge CLK_IN);
  endtask

  initial begin
    logic [23:0] w;
    RST_N      = 1'b0;
    Ws2812_Din = 1'b0;
    repeat (3) @(negedge CLK_IN);

    // Reset state
    check("rst_data",  Rx_Data,     0);
    check("rst_valid", Rx_Valid,    0);
    check("rst_index", Rx_Index,    0);
    check("rst_fd",    Frame_Done,  0);
    check("rst_err",   Rx_Error,    0);
    check("rst_dout",  Ws2812_Dout, 0);

    // Initial reset gap leaves WAIT_RESET without a Frame_Done
    RST_N = 1'b1;
    idle(620);
    check("boot_no_fd", fd_cnt, 0);

    // 0xA5C3F0 with exact latency on the final (zero) bit
    w = 24'hA5C3F0;
    for (int i = 23; i >= 1; i--) send_bit(w[i]);
    Ws2812_Din = 1'b1;
    repeat (4) @(negedge CLK_IN);
    Ws2812_Din = 1'b0;
    repeat (3) @(negedge CLK_IN);
    check("lat_early", Rx_Valid, 0);
    @(negedge CLK_IN);
    check("lat_valid", Rx_Valid, 1);
    idle(10);
    check_rx("w_a5c3f0", 24'hA5C3F0, 8'd0);
    check_none("w_a5c3f0_extra");

    fd_base = fd_cnt;
    idle(620);
    check("fd_after_first", fd_cnt - fd_base, 1);

    // Two back-to-back words, then the reset gap
    fd_base = fd_cnt;
    send_word(24'h123456);
    send_word(24'hFEDCBA);
    idle(620);
    check_rx("w_123456", 24'h123456, 8'd0);
    check_rx("w_fedcba", 24'hFEDCBA, 8'd1);
    check_none("two_extra");
    check("two_fd", fd_cnt - fd_base, 1);
    check("data_hold", Rx_Data, 24'hFEDCBA);

    // Threshold: 7 high -> 0, 8 high -> 1
    for (int i = 23; i >= 6; i--) send_bit(1'b0);
    pulse(7, 8);
    pulse(8, 7);
    for (int i = 3; i >= 0; i--) send_bit(1'b0);
    idle(620);
    check_rx("thresh", 24'h000010, 8'd0);

    // Partial 10 bits discarded by the reset gap
    fd_base = fd_cnt;
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    idle(620);
    check_none("partial_none");
    check("partial_fd", fd_cnt - fd_base, 1);
    send_word(24'h00FF00);
    idle(20);
    check_rx("w_00ff00", 24'h00FF00, 8'd0);
    idle(620);

    // RESET_CYC-1 low is an ordinary gap
    fd_base = fd_cnt;
    w = 24'hC0FFEE;
    for (int i = 23; i >= 13; i--) send_bit(w[i]);
    pulse(w[12] ? 10 : 4, 599);
    for (int i = 11; i >= 0; i--) send_bit(w[i]);
    idle(20);
    check_rx("gap599", 24'hC0FFEE, 8'd0);
    check("gap599_no_fd", fd_cnt - fd_base, 0);
    idle(620);

    // 60-cycle high is legal
    pulse(60, 5);
    for (int i = 22; i >= 0; i--) send_bit(1'b0);
    idle(20);
    check_rx("high60", 24'h800000, 8'd0);
    check("high60_err", Rx_Error, 0);
    idle(620);

    // 61-cycle high sets the sticky error and edges are ignored
    fd_base = fd_cnt;
    pulse(61, 50);
    check("err_set", Rx_Error, 1);
    send_word(24'hFFFFFF);
    check_none("err_ignored");
    check("err_sticky", Rx_Error, 1);
    idle(620);
    check("err_cleared", Rx_Error, 0);
    check("err_no_fd", fd_cnt - fd_base, 0);
    send_word(24'h5A5A5A);
    idle(20);
    check_rx("after_err", 24'h5A5A5A, 8'd0);

    // Asynchronous reset in the middle of a word
    fd_base = fd_cnt;
    for (int i = 0; i < 12; i++) send_bit(1'b1);
    Ws2812_Din = 1'b1;
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_data",  Rx_Data,  0);
    check("arst_index", Rx_Index, 0);
    check("arst_err",   Rx_Error, 0);
    @(negedge CLK_IN);
    Ws2812_Din = 1'b0;
    repeat (3) @(negedge CLK_IN);
    RST_N = 1'b1;
    send_word(24'h111111);
    check_none("arst_wait");
    idle(620);
    check_none("arst_partial");
    check("arst_no_fd", fd_cnt - fd_base, 0);
    send_word(24'h2468AC);
    idle(20);
    check_rx("arst_next", 24'h2468AC, 8'd0);
    idle(620);

    // Index saturation: 257 fast zero words in one frame
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < 24; i++) pulse(1, 1);
    end
    idle(20);
    check("sat_count", q_dat.size(), 257);
    if (q_dat.size() == 257) begin
      check("sat_idx254", q_idx[254], 254);
      check("sat_idx255", q_idx[255], 255);
      check("sat_idx256", q_idx[256], 255);
      check("sat_dat256", q_dat[256], 0);
    end
    q_dat.delete();
    q_idx.delete();
    idle(620);
    check("sat_idx_clear", Rx_Index, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
